lc4_insn_queue: RTL

- 4-entry circular instruction queue / reorder buffer directly downstream of the fetch stage.
- Accepts one decoded instruction per cycle from fetch, issues the oldest un-issued entry to execute over a valid/ready handshake, and records completions.
- Retires completed entries strictly in order from the head.
- Exports per-slot insn and valid/issue/commit bit vectors for the fetch-side scoreboard, plus rob_full for fetch stall generation.

---
 rtl/lc4_insn_queue_if.sv | 45 ++++
 rtl/lc4_insn_queue.sv | 132 +++++++++++++
 2 files changed

// File: rtl/lc4_insn_queue_if.sv
// Bus bundle between fetch/execute and the instruction queue.
// master = the pipeline side driving requests, slave = the queue itself.
interface lc4_insn_queue_if;
    logic        enq_valid;
    logic [15:0] enq_insn;
    logic [15:0] enq_pc;
    logic        rob_full;

    logic        issue_valid;
    logic        issue_ready;
    logic [1:0]  issue_idx;
    logic [15:0] issue_insn;
    logic [15:0] issue_pc;

    logic        cmpl_valid;
    logic [1:0]  cmpl_idx;

    logic        retire_valid;
    logic [15:0] retire_insn;
    logic [15:0] retire_pc;

    logic        flush;

    logic [15:0] iq0_insn;
    logic [15:0] iq1_insn;
    logic [15:0] iq2_insn;
    logic [15:0] iq3_insn;
    logic [3:0]  iq_valid;
    logic [3:0]  iq_issue;
    logic [3:0]  iq_commit;

    modport master (
        output enq_valid, enq_insn, enq_pc, issue_ready, cmpl_valid, cmpl_idx, flush,
        input  rob_full, issue_valid, issue_idx, issue_insn, issue_pc,
               retire_valid, retire_insn, retire_pc,
               iq0_insn, iq1_insn, iq2_insn, iq3_insn, iq_valid, iq_issue, iq_commit
    );

    modport slave (
        input  enq_valid, enq_insn, enq_pc, issue_ready, cmpl_valid, cmpl_idx, flush,
        output rob_full, issue_valid, issue_idx, issue_insn, issue_pc,
               retire_valid, retire_insn, retire_pc,
               iq0_insn, iq1_insn, iq2_insn, iq3_insn, iq_valid, iq_issue, iq_commit
    );
endinterface

// File: rtl/lc4_insn_queue.sv
// 4-entry circular instruction queue / reorder buffer behind fetch.
// In-order enqueue at tail, oldest-first issue, out-of-order completion,
// in-order retire from head. All outputs decode registered state only.
module lc4_insn_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                clk,
    input  logic                rst,
    lc4_insn_queue_if.slave     q
);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] issued_q, issued_d;
    logic [DEPTH-1:0] done_q, done_d;
    logic [15:0]      insn_q [DEPTH];
    logic [15:0]      insn_d [DEPTH];
    logic [15:0]      pc_q [DEPTH];
    logic [15:0]      pc_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [2:0]       count_q, count_d;

    logic             rob_full;
    logic             enq;
    logic             retire_now;
    logic             iss_found;
    logic [PTR_W-1:0] iss_idx;
    logic [PTR_W-1:0] cand;

    assign rob_full   = (count_q == 3'(DEPTH));
    assign enq        = q.enq_valid & ~rob_full;
    assign retire_now = valid_q[head_q] & done_q[head_q];

    // Oldest valid, not-yet-issued slot, scanning from head in age order.
    always_comb begin
        iss_found = 1'b0;
        iss_idx   = '0;
        cand      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            cand = head_q + PTR_W'(k);
            if (!iss_found && valid_q[cand] && !issued_q[cand]) begin
                iss_found = 1'b1;
                iss_idx   = cand;
            end
        end
    end

    assign q.rob_full     = rob_full;
    assign q.issue_valid  = iss_found;
    assign q.issue_idx    = iss_idx;
    assign q.issue_insn   = iss_found ? insn_q[iss_idx] : 16'h0000;
    assign q.issue_pc     = iss_found ? pc_q[iss_idx] : 16'h0000;
    assign q.retire_valid = retire_now;
    assign q.retire_insn  = retire_now ? insn_q[head_q] : 16'h0000;
    assign q.retire_pc    = retire_now ? pc_q[head_q] : 16'h0000;
    assign q.iq0_insn     = insn_q[0];
    assign q.iq1_insn     = insn_q[1];
    assign q.iq2_insn     = insn_q[2];
    assign q.iq3_insn     = insn_q[3];
    assign q.iq_valid     = valid_q;
    assign q.iq_issue     = issued_q;
    assign q.iq_commit    = valid_q & done_q;

    // Next state: completion sees the old issued bit, retire clears head before
    // enqueue writes tail (they never collide), flush overrides everything.
    always_comb begin
        valid_d  = valid_q;
        issued_d = issued_q;
        done_d   = done_q;
        insn_d   = insn_q;
        pc_d     = pc_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q + 3'(enq) - 3'(retire_now);

        if (q.cmpl_valid && valid_q[q.cmpl_idx] && issued_q[q.cmpl_idx]) begin
            done_d[q.cmpl_idx] = 1'b1;
        end
        if (iss_found && q.issue_ready) begin
            issued_d[iss_idx] = 1'b1;
        end
        if (retire_now) begin
            valid_d[head_q]  = 1'b0;
            issued_d[head_q] = 1'b0;
            done_d[head_q]   = 1'b0;
            head_d           = head_q + 1'b1;
        end
        if (enq) begin
            valid_d[tail_q]  = 1'b1;
            issued_d[tail_q] = 1'b0;
            done_d[tail_q]   = 1'b0;
            insn_d[tail_q]   = q.enq_insn;
            pc_d[tail_q]     = q.enq_pc;
            tail_d           = tail_q + 1'b1;
        end
        if (q.flush) begin
            valid_d  = '0;
            issued_d = '0;
            done_d   = '0;
            head_d   = '0;
            tail_d   = '0;
            count_d  = '0;
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q  <= '0;
            issued_q <= '0;
            done_q   <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                insn_q[i] <= 16'h0000;
                pc_q[i]   <= 16'h0000;
            end
        end else begin
            valid_q  <= valid_d;
            issued_q <= issued_d;
            done_q   <= done_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            insn_q   <= insn_d;
            pc_q     <= pc_d;
        end
    end

endmodule
